// File: rtl/key_event_bank.sv
// N-channel push-button front end: shared sample tick, per-key debounce and
// press/release/click/long-press/auto-repeat event generation on clk.
module key_event_chan #(
    parameter int DEB_TICKS    = 3,
    parameter int LONG_TICKS   = 250,
    parameter int REPEAT_TICKS = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic clr,
    input  logic s,
    input  logic repeat_en,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic click,
    output logic long_press,
    output logic repeat_pulse
);
    localparam int DEB_W  = $clog2(DEB_TICKS + 1);
    localparam int HOLD_W = $clog2(LONG_TICKS + 1);
    localparam int REP_W  = $clog2(REPEAT_TICKS + 1);

    typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;

    state_t            state;
    logic [DEB_W-1:0]  deb_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [REP_W-1:0]  rep_cnt;
    logic              deb_hit, rise, fall;

    // The FSM reacts to the debounce decision of the same tick, so press and
    // release land on the same edge as the level change.
    always_comb begin
        deb_hit = (s != level) && (deb_cnt == DEB_W'(DEB_TICKS - 1));
        rise    = deb_hit & ~level;
        fall    = deb_hit & level;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            level         <= 1'b0;
            deb_cnt       <= '0;
            hold_cnt      <= '0;
            rep_cnt       <= '0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            click         <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            press         <= 1'b0;
            release_pulse <= 1'b0;
            click         <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            if (clr) begin
                state    <= IDLE;
                level    <= 1'b0;
                deb_cnt  <= '0;
                hold_cnt <= '0;
                rep_cnt  <= '0;
            end else if (tick) begin
                if (s == level) begin
                    deb_cnt <= '0;
                end else if (deb_hit) begin
                    deb_cnt <= '0;
                    level   <= ~level;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end

                case (state)
                    IDLE: begin
                        if (rise) begin
                            press    <= 1'b1;
                            hold_cnt <= '0;
                            state    <= HELD;
                        end
                    end
                    HELD: begin
                        if (fall) begin
                            release_pulse <= 1'b1;
                            click         <= 1'b1;
                            state         <= IDLE;
                        end else if (hold_cnt == HOLD_W'(LONG_TICKS - 1)) begin
                            long_press <= 1'b1;
                            hold_cnt   <= '0;
                            rep_cnt    <= '0;
                            state      <= LONG;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    LONG: begin
                        if (fall) begin
                            release_pulse <= 1'b1;
                            state         <= IDLE;
                        end else if (!repeat_en) begin
                            rep_cnt <= '0;
                        end else if (rep_cnt == REP_W'(REPEAT_TICKS - 1)) begin
                            repeat_pulse <= 1'b1;
                            rep_cnt      <= '0;
                        end else begin
                            rep_cnt <= rep_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// release/repeat are SystemVerilog keywords, hence the _pulse suffix on those ports.
module key_event_bank #(
    parameter int N_KEYS       = 7,
    parameter int TICK_DIV     = 200000,
    parameter int DEB_TICKS    = 3,
    parameter int LONG_TICKS   = 250,
    parameter int REPEAT_TICKS = 50,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] keys,
    input  logic              clr,
    input  logic [N_KEYS-1:0] repeat_en,
    output logic [N_KEYS-1:0] level,
    output logic [N_KEYS-1:0] press,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] click,
    output logic [N_KEYS-1:0] long_press,
    output logic [N_KEYS-1:0] repeat_pulse,
    output logic              tick
);
    localparam int   DIV_W = $clog2(TICK_DIV);
    localparam logic REL   = (ACTIVE_LOW != 0);

    logic [DIV_W-1:0]  div_cnt;
    logic [N_KEYS-1:0] sync1, sync2, s;

    // tick is registered one count early so it is high exactly while div_cnt == TICK_DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick    <= (div_cnt == DIV_W'(TICK_DIV - 2));
            div_cnt <= (div_cnt == DIV_W'(TICK_DIV - 1)) ? '0 : div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= {N_KEYS{REL}};
            sync2 <= {N_KEYS{REL}};
        end else begin
            sync1 <= keys;
            sync2 <= sync1;
        end
    end

    assign s = REL ? ~sync2 : sync2;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
        key_event_chan #(
            .DEB_TICKS   (DEB_TICKS),
            .LONG_TICKS  (LONG_TICKS),
            .REPEAT_TICKS(REPEAT_TICKS)
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .tick         (tick),
            .clr          (clr),
            .s            (s[i]),
            .repeat_en    (repeat_en[i]),
            .level        (level[i]),
            .press        (press[i]),
            .release_pulse(release_pulse[i]),
            .click        (click[i]),
            .long_press   (long_press[i]),
            .repeat_pulse (repeat_pulse[i])
        );
    end
endmodule

// File: tb/tb_key_event_bank.sv
// Scoreboard bench for key_event_bank: stimulus queues expected events with
// hand-computed cycle stamps; a negedge monitor pops and compares them.
module tb_key_event_bank;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] keys = 3'b000;
    logic       clr = 1'b0;
    logic [2:0] repeat_en = 3'b000;
    logic [2:0] level, press, release_pulse, click, long_press, repeat_pulse;
    logic       tick;

    key_event_bank #(
        .N_KEYS(3), .TICK_DIV(4), .DEB_TICKS(3),
        .LONG_TICKS(10), .REPEAT_TICKS(4), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .keys(keys), .clr(clr), .repeat_en(repeat_en),
        .level(level), .press(press), .release_pulse(release_pulse), .click(click),
        .long_press(long_press), .repeat_pulse(repeat_pulse), .tick(tick)
    );

    typedef struct {
        int         cyc;
        logic [2:0] p, r, c, l, t, lv;
    } ev_t;

    ev_t q[$];
    ev_t mon_e;
    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    int  base = 0;
    bit  run = 1'b0;
    logic exp_tick;

    always #5 clk = ~clk;

    always @(posedge clk) if (run) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (run && rst_n) begin
            exp_tick = (((cyc - base) % 4) == 3);
            checks++;
            if (tick !== exp_tick) begin
                errors++;
                $display("FAIL tick cyc=%0d got=%b want=%b", cyc, tick, exp_tick);
            end
            if (|{press, release_pulse, click, long_press, repeat_pulse}) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event cyc=%0d got p=%b r=%b c=%b l=%b t=%b lv=%b",
                             cyc, press, release_pulse, click, long_press, repeat_pulse, level);
                end else begin
                    mon_e = q.pop_front();
                    if (mon_e.cyc != cyc || mon_e.p !== press || mon_e.r !== release_pulse ||
                        mon_e.c !== click || mon_e.l !== long_press || mon_e.t !== repeat_pulse ||
                        mon_e.lv !== level) begin
                        errors++;
                        $display("FAIL event got cyc=%0d p=%b r=%b c=%b l=%b t=%b lv=%b want cyc=%0d p=%b r=%b c=%b l=%b t=%b lv=%b",
                                 cyc, press, release_pulse, click, long_press, repeat_pulse, level,
                                 mon_e.cyc, mon_e.p, mon_e.r, mon_e.c, mon_e.l, mon_e.t, mon_e.lv);
                    end
                end
            end
        end
    end

    task automatic expect_ev(input int c, input logic [2:0] p, r, cl, l, t, lv);
        ev_t e;
        e.cyc = c; e.p = p; e.r = r; e.c = cl; e.l = l; e.t = t; e.lv = lv;
        q.push_back(e);
    endtask

    task automatic at_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({level, press, release_pulse, click, long_press, repeat_pulse, tick} !== '0) begin
            errors++;
            $display("FAIL %s got lv=%b p=%b r=%b c=%b l=%b t=%b tick=%b want all zero",
                     name, level, press, release_pulse, click, long_press, repeat_pulse, tick);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // All keys held (active low) through reset
        repeat (3) @(negedge clk);
        check_zero("reset");
        expect_ev(12, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b111);
        rst_n = 1'b1;
        run   = 1'b1;

        at_cyc(16); keys = 3'b111;
        expect_ev(28, 3'b000, 3'b111, 3'b111, 3'b000, 3'b000, 3'b000);

        // Bounce on key0, then a short press -> click
        at_cyc(32); keys = 3'b110;
        at_cyc(40); keys = 3'b111;
        at_cyc(44); keys = 3'b110;
        expect_ev(56, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001);
        at_cyc(76); keys = 3'b111;
        expect_ev(88, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000);

        // Long hold on key1 with repeat enabled
        at_cyc(92); repeat_en = 3'b010; keys = 3'b101;
        expect_ev(104, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010);
        expect_ev(144, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 3'b010);
        for (int k = 1; k <= 4; k++)
            expect_ev(144 + 16 * k, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b010);
        at_cyc(212); keys = 3'b111;
        expect_ev(224, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000);

        // Long hold on key2 with repeat disabled
        at_cyc(228); repeat_en = 3'b000; keys = 3'b011;
        expect_ev(240, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100);
        expect_ev(280, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 3'b100);
        at_cyc(348); keys = 3'b111;
        expect_ev(360, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000);

        // Simultaneous key0 + key2
        at_cyc(364); keys = 3'b010;
        expect_ev(376, 3'b101, 3'b000, 3'b000, 3'b000, 3'b000, 3'b101);
        at_cyc(380); keys = 3'b111;
        expect_ev(392, 3'b000, 3'b101, 3'b101, 3'b000, 3'b000, 3'b000);

        // clr during LONG on key1: silent drop, then fresh press
        at_cyc(396); keys = 3'b101;
        expect_ev(408, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010);
        expect_ev(448, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 3'b010);
        at_cyc(452); clr = 1'b1;
        at_cyc(453); clr = 1'b0;
        expect_ev(464, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010);
        expect_ev(504, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 3'b010);
        at_cyc(456);
        checks++;
        if (level !== 3'b000) begin
            errors++;
            $display("FAIL clr_level got=%b want=000", level);
        end

        // Reset mid-hold: clears at once, then re-press after full debounce
        at_cyc(508); rst_n = 1'b0;
        #1 check_zero("mid_hold_reset");
        at_cyc(510);
        base = 510;
        expect_ev(522, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010);
        rst_n = 1'b1;
        at_cyc(526); keys = 3'b111;
        expect_ev(538, 3'b000, 3'b010, 3'b010, 3'b000, 3'b000, 3'b000);

        at_cyc(560);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_events got=%0d want=0 next_cyc=%0d", q.size(), q[0].cyc);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
